// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multi-cycle RV32 controller.
//   States, supported opcodes, alu_ctrl codes, imm_src codes and the
//   operand / result mux select codes driven by multicycle_controller.
package riscv_ctrl_pkg;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECR    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_TRAP     = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps R-type funct3/funct7_5 to an ALU operation.
//   funct3, funct7_5 in  : instruction function fields
//   alu_ctrl         out : ALU operation code
//   legal            out : 1 when the combination is a supported R-type op
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct3)
            3'b000:  alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ctrl = ALU_AND;
            3'b110:  alu_ctrl = ALU_OR;
            3'b010:  alu_ctrl = ALU_SLT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle control FSM for the RV32 datapath
//   (lw, sw, beq, R-type add/sub/and/or/slt) with a retired-instruction count.
//   opcode/funct3/funct7_5 in : IR fields; zero in : ALU zero flag
//   mem_ready in : memory handshake; mem_req/mem_we/adr_src out : memory request
//   ir_write/pc_write/reg_write out : register enables
//   imm_src/alu_src_a/alu_src_b/alu_ctrl/result_src out : datapath selects
//   illegal out : sticky trap flag; instret out : retired-instruction count
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           imm_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_ctrl,
    output logic [1:0]           result_src,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    logic [3:0] state, state_next;
    logic [2:0] dec_ctrl;
    logic       dec_legal;
    logic       retire;
    logic       is_store;

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (dec_ctrl),
        .legal    (dec_legal)
    );

    assign is_store = opcode == OP_STORE;

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        imm_src    = IMM_I;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_ctrl   = ALU_ADD;
        result_src = RES_ALUOUT;
        illegal    = 1'b0;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                // IR and PC load only on the cycle the fetch completes
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures the branch target for a possible beq
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_B;
                state_next = (opcode == OP_LOAD || is_store) ? S_MEMADR :
                             (opcode == OP_RTYPE && dec_legal) ? S_EXECR :
                             opcode == OP_BRANCH ? S_BEQ : S_TRAP;
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                imm_src    = is_store ? IMM_S : IMM_I;
                state_next = is_store ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                adr_src    = 1'b1;
                retire     = mem_ready;
                state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_ctrl   = dec_ctrl;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                // PC takes the target held in ALUOut only when rs1 == rs2
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_ctrl   = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP:  illegal = 1'b1;
            default: state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            instret <= '0;
        end else begin
            state <= state_next;
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
//   A stimulus process plays instructions with random handshake waits and
//   queues the expected output vector of every cycle; a negedge monitor
//   pops and compares. A second instance with INSTRET_W=4 checks wrapping.
module tb_multicycle_controller;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        logic [1:0]  imm_src;
        logic [1:0]  alu_src_a;
        logic [1:0]  alu_src_b;
        logic [2:0]  alu_ctrl;
        logic [1:0]  result_src;
        logic        illegal;
        logic [31:0] instret;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  imm_src, alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] instret;
    logic        mem_req_4, mem_we_4, adr_src_4, ir_write_4, pc_write_4, reg_write_4, illegal_4;
    logic [1:0]  imm_src_4, alu_src_a_4, alu_src_b_4, result_src_4;
    logic [2:0]  alu_ctrl_4;
    logic [3:0]  instret_4;
    obs_t        act;

    obs_t        exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned model_cnt = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .result_src(result_src), .illegal(illegal), .instret(instret)
    );

    multicycle_controller #(.INSTRET_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req_4), .mem_we(mem_we_4),
        .adr_src(adr_src_4), .ir_write(ir_write_4), .pc_write(pc_write_4),
        .reg_write(reg_write_4), .imm_src(imm_src_4), .alu_src_a(alu_src_a_4),
        .alu_src_b(alu_src_b_4), .alu_ctrl(alu_ctrl_4), .result_src(result_src_4),
        .illegal(illegal_4), .instret(instret_4)
    );

    assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_src,
                  alu_src_a, alu_src_b, alu_ctrl, result_src, illegal, instret};

    task automatic check(input string nm, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic check_n(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  w;
            string nm;
            w  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, act, w);
            check_n({nm, ".instret4"}, 32'(instret_4), 32'(w.instret[3:0]));
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t idle();
        obs_t o = '0;
        o.instret = model_cnt;
        return o;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7);
        return f3 == 3'b000 ? (f7 ? 3'b001 : 3'b000) :
               f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 : 3'b101;
    endfunction

    task automatic cyc(input string nm, input logic rdy, input logic z, input obs_t o);
        exp_q.push_back(o);
        name_q.push_back(nm);
        mem_ready = rdy;
        zero      = z;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", act, obs_t'('0));
        check_n("reset_async.instret4", 32'(instret_4), 0);
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("reset_state", rb(), rb(), idle());
    endtask

    task automatic fetch(input int waits);
        obs_t o = idle();
        o.mem_req = 1'b1;
        o.alu_src_b = 2'b10;
        o.result_src = 2'b10;
        for (int i = 0; i < waits; i++) cyc("fetch_wait", 1'b0, rb(), o);
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
        cyc("fetch", 1'b1, rb(), o);
    endtask

    task automatic decode();
        obs_t o = idle();
        o.alu_src_a = 2'b01;
        o.alu_src_b = 2'b01;
        o.imm_src = 2'b10;
        cyc("decode", rb(), rb(), o);
    endtask

    task automatic memadr(input logic store);
        obs_t o = idle();
        o.alu_src_a = 2'b10;
        o.alu_src_b = 2'b01;
        o.imm_src = store ? 2'b01 : 2'b00;
        cyc(store ? "sw.memadr" : "lw.memadr", rb(), rb(), o);
    endtask

    task automatic run_lw(input int fw, input int mw);
        obs_t o;
        opcode = 7'b0000011;
        funct3 = 3'($urandom);
        fetch(fw);
        decode();
        memadr(1'b0);
        o = idle();
        o.mem_req = 1'b1;
        o.adr_src = 1'b1;
        for (int i = 0; i < mw; i++) cyc("lw.memread_wait", 1'b0, rb(), o);
        cyc("lw.memread", 1'b1, rb(), o);
        o = idle();
        o.result_src = 2'b01;
        o.reg_write = 1'b1;
        cyc("lw.memwb", rb(), rb(), o);
        model_cnt++;
    endtask

    task automatic run_sw(input int fw, input int mw);
        obs_t o;
        opcode = 7'b0100011;
        funct3 = 3'($urandom);
        fetch(fw);
        decode();
        memadr(1'b1);
        o = idle();
        o.mem_req = 1'b1;
        o.mem_we = 1'b1;
        o.adr_src = 1'b1;
        for (int i = 0; i < mw; i++) cyc("sw.memwrite_wait", 1'b0, rb(), o);
        cyc("sw.memwrite", 1'b1, rb(), o);
        model_cnt++;
    endtask

    task automatic run_beq(input int fw, input logic z);
        obs_t o;
        opcode = 7'b1100011;
        fetch(fw);
        decode();
        o = idle();
        o.alu_src_a = 2'b10;
        o.alu_ctrl = 3'b001;
        o.pc_write = z;
        cyc("beq", rb(), z, o);
        model_cnt++;
    endtask

    task automatic run_r(input int fw, input logic [2:0] f3, input logic f7);
        obs_t o;
        opcode = 7'b0110011;
        funct3 = f3;
        funct7_5 = f7;
        fetch(fw);
        decode();
        o = idle();
        o.alu_src_a = 2'b10;
        o.alu_ctrl = ref_alu(f3, f7);
        cyc("execr", rb(), rb(), o);
        o = idle();
        o.reg_write = 1'b1;
        cyc("aluwb", rb(), rb(), o);
        model_cnt++;
    endtask

    task automatic run_trap(input int fw, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input int n);
        obs_t o;
        opcode = op;
        funct3 = f3;
        funct7_5 = f7;
        fetch(fw);
        decode();
        o = idle();
        o.illegal = 1'b1;
        for (int i = 0; i < n; i++) cyc("trap", rb(), rb(), o);
    endtask

    task automatic pick_legal(output logic [2:0] f3, output logic f7);
        int k = int'($urandom_range(0, 4));
        f3 = k <= 1 ? 3'b000 : k == 2 ? 3'b111 : k == 3 ? 3'b110 : 3'b010;
        f7 = k == 1 ? 1'b1 : k == 0 ? 1'b0 : rb();
    endtask

    task automatic random_trap();
        logic [2:0] bad_f3[4] = '{3'b001, 3'b011, 3'b100, 3'b101};
        logic [6:0] op;
        if (rb()) begin
            run_trap(int'($urandom_range(0, 2)), 7'b0110011, bad_f3[$urandom_range(0, 3)],
                     rb(), int'($urandom_range(1, 4)));
        end else begin
            do op = 7'($urandom);
            while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011 || op == 7'b0110011);
            run_trap(int'($urandom_range(0, 2)), op, 3'($urandom), rb(), int'($urandom_range(1, 4)));
        end
        do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] f3;
        logic       f7;
        obs_t       o;
        #2;
        do_reset();
        run_lw(0, 0);
        run_sw(0, 2);
        run_beq(0, 1'b1);
        run_beq(0, 1'b0);
        run_r(0, 3'b000, 1'b1);
        run_trap(0, 7'b0110011, 3'b001, 1'b0, 10);
        do_reset();
        opcode = 7'b0000011;
        fetch(0);
        decode();
        memadr(1'b0);
        o = idle();
        o.mem_req = 1'b1;
        o.adr_src = 1'b1;
        exp_q.push_back(o);
        name_q.push_back("lw.memread_before_reset");
        mem_ready = 1'b0;
        @(negedge clk);
        #2;
        do_reset();
        run_lw(1, 1);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pick_legal(f3, f7);
            run_r(0, f3, f7);
        end
        check_n("wrap.instret4", 32'(instret_4), 0);
        check_n("wrap.instret", instret, 16);
        for (int i = 0; i < 80; i++) begin
            int k = int'($urandom_range(0, 9));
            int fw = int'($urandom_range(0, 2));
            if (k <= 1) run_lw(fw, int'($urandom_range(0, 2)));
            else if (k <= 3) run_sw(fw, int'($urandom_range(0, 2)));
            else if (k <= 5) run_beq(fw, rb());
            else if (k <= 8) begin
                pick_legal(f3, f7);
                run_r(fw, f3, f7);
            end else random_trap();
        end
        @(negedge clk);
        #1;
        check_n("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the RV32 core datapath. Sequences fetch, decode, address generation, memory access and write-back for the supported subset: lw, sw, beq and R-type add/sub/and/or/slt. Drives the immediate generator select, ALU operand muxes, register-file write, PC/IR enables and a req/ready memory handshake. Also counts retired instructions.

## Interface
- INSTRET_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  instruction[6:0] from the IR
- funct3  in  3  instruction[14:12]
- funct7_5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepts or completes the current request
- mem_req  out  1  memory request valid
- mem_we  out  1  write request (valid only with mem_req)
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut register
- ir_write  out  1  IR and old-PC register load enable
- pc_write  out  1  PC load enable
- reg_write  out  1  register-file write enable
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B
- alu_src_a  out  2  ALU A operand: 00 = PC, 01 = old PC, 10 = rs1 register
- alu_src_b  out  2  ALU B operand: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- alu_ctrl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- result_src  out  2  write-back/PC source: 00 = ALUOut, 01 = memory data, 10 = ALU result
- illegal  out  1  sticky unsupported-instruction flag
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, BEQ, TRAP.
- Outputs are decoded from the state; any output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle (Mealy, qualified by mem_ready), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, add (precomputes the branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 with a legal funct3/funct7_5 → EXECR
  - 1100011 → BEQ
  - anything else → TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src=00 for lw (next state MEMREAD), imm_src=01 for sw (next state MEMWRITE).
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Retires; go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Retires on mem_ready, then go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_ctrl from funct decode. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Retires; go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero. Retires; go to FETCH.
- TRAP: illegal=1. Stays in TRAP until rst_n is asserted.
- Funct decode:
  - 000 with funct7_5=0 → add
  - 000 with funct7_5=1 → sub
  - 111 → and
  - 110 → or
  - 010 → slt
  - any other combination is illegal.
- instret increments by 1 in each retiring cycle and wraps from 2^INSTRET_W−1 to 0.

## Timing
- Reset values: state RESET, instret=0, illegal=0, every other output 0. Outputs reach these values immediately on rst_n assertion, asynchronously.
- Reset mid-operation (any state, including a pending memory wait): the request is dropped and there is no retire.
- Memory handshake:
  - A transfer completes in a cycle where mem_req=1 and mem_ready=1.
  - mem_req, mem_we and adr_src stay stable until that cycle.
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Zero-wait instruction latencies:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - beq: 3 cycles
- Each wait cycle at a memory handshake adds 1 cycle.
- First FETCH occurs 1 cycle after rst_n deasserts.
- The next instruction's FETCH immediately follows the retire cycle. There are no idle cycles.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - state encoding
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE)
  - alu_ctrl codes
  - imm_src codes
  - operand-mux select codes
- One sub-module, alu_decoder: combinational, funct3/funct7_5 → alu_ctrl plus a legal flag. The controller uses the legal flag in DECODE and alu_ctrl in EXECR.

## Test plan
- Reset, then lw (0000011) with mem_ready always 1:
  - state sequence FETCH, DECODE, MEMADR (imm_src=00), MEMREAD, MEMWB
  - reg_write=1 and result_src=01 in cycle 5
  - instret goes 0 → 1
- sw (0100011) with mem_ready low for 2 cycles in MEMWRITE:
  - mem_req=1, mem_we=1 and adr_src=1 held for 3 cycles
  - imm_src=01 in MEMADR
  - instret increments on the ready cycle
- beq (1100011):
  - zero=1 → pc_write=1 with alu_ctrl=001 in BEQ
  - zero=0 → pc_write=0
  - 3 cycles each
- R-type funct3=000 with funct7_5=1 → alu_ctrl=001 in EXECR, reg_write=1 in ALUWB. funct3=001 → TRAP, illegal=1 held across 10 cycles.
- rst_n asserted in MEMREAD with mem_req=1: all outputs 0 in the same cycle, no instret change, FETCH 1 cycle after release.
- INSTRET_W=4: 16 back-to-back R-type instructions → instret wraps from 15 to 0.
